// File: rtl/jtcps1_bank_sched.sv
// Arbitrates the four CPS SDRAM bank requesters onto one controller command port
// and inserts auto-refresh, deferring it to vertical blank when video is active.
module jtcps1_bank_sched #(
  parameter int AW          = 23,
  parameter int PRIO0       = 1,
  parameter int RFSH_PERIOD = 750,
  parameter int RFSH_MAX    = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  input  logic          ba_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_rdy,
  output logic          sdram_req,
  output logic          sdram_rfsh,
  output logic [1:0]    sdram_ba,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_wr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_mask,
  input  logic          sdram_gnt,
  input  logic          sdram_dst,
  input  logic          sdram_rdy,
  output logic          err,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RFSH  = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;

  localparam int CNT_W = $clog2(RFSH_PERIOD);
  localparam int AGE_W = $clog2(RFSH_MAX + 1);

  // Handshake: sdram_req/sdram_rfsh are valid and held with stable command
  // fields until sdram_gnt is sampled high; that cycle completes the transfer.
  logic [2:0]       state;
  logic [1:0]       sel;
  logic [1:0]       last_ba;
  logic [7:0]       to_cnt;
  logic [CNT_W-1:0] rfsh_cnt;
  logic             rfsh_pend;
  logic [AGE_W-1:0] rfsh_age;

  logic [3:0]    cand;
  logic          rfsh_go;
  logic          pick_vld;
  logic [1:0]    pick;
  logic [1:0]    scan_idx;
  logic [AW-1:0] pick_addr;
  logic [3:0]    sel_oh;
  logic          rfsh_wrap;

  always_comb begin
    cand     = ba_rd | {3'b0, ba_wr};
    rfsh_go  = rfsh_pend && (!LVBL || rfsh_age >= AGE_W'(RFSH_MAX) || cand == 4'd0);
    pick_vld = 1'b0;
    pick     = 2'd0;
    scan_idx = 2'd0;
    if (PRIO0 != 0 && cand[0]) begin
      pick_vld = 1'b1;
      pick     = 2'd0;
    end else begin
      // Scan farthest offset first so the nearest bank after last_ba wins.
      for (int i = 4; i >= 1; i--) begin
        scan_idx = last_ba + 2'(i);
        if (cand[scan_idx]) begin
          pick_vld = 1'b1;
          pick     = scan_idx;
        end
      end
    end
  end

  always_comb begin
    case (pick)
      2'd0:    pick_addr = ba0_addr;
      2'd1:    pick_addr = ba1_addr;
      2'd2:    pick_addr = ba2_addr;
      default: pick_addr = ba3_addr;
    endcase
  end

  assign rfsh_wrap = (rfsh_cnt == CNT_W'(RFSH_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      last_ba    <= 2'd3;
      to_cnt     <= 8'd0;
      rfsh_cnt   <= '0;
      rfsh_pend  <= 1'b0;
      rfsh_age   <= '0;
      sdram_addr <= '0;
      sdram_wr   <= 1'b0;
      sdram_din  <= 16'd0;
      sdram_mask <= 2'd0;
      err        <= 1'b0;
    end else begin
      rfsh_cnt <= rfsh_wrap ? '0 : rfsh_cnt + 1'b1;
      if (state == RFSH && sdram_gnt) begin
        rfsh_pend <= 1'b0;
        rfsh_age  <= '0;
      end else if (rfsh_pend && rfsh_age != AGE_W'(RFSH_MAX)) begin
        rfsh_age <= rfsh_age + 1'b1;
      end
      // A wrap that lands on the grant cycle starts the next period's request.
      if (rfsh_wrap) rfsh_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (rfsh_go) begin
            state <= RFSH;
          end else if (pick_vld) begin
            state      <= REQ;
            sel        <= pick;
            sdram_addr <= pick_addr;
            sdram_wr   <= (pick == 2'd0) && ba_wr;
            sdram_din  <= ba0_din;
            sdram_mask <= ba0_din_m;
          end
        end
        REQ: begin
          if (sdram_gnt) begin
            state  <= WAIT;
            to_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (sdram_rdy) begin
            state   <= IDLE;
            last_ba <= sel;
          end else if (to_cnt == 8'(TIMEOUT - 1)) begin
            state   <= IDLE;
            last_ba <= sel;
            err     <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        RFSH:    if (sdram_gnt) state <= RWAIT;
        RWAIT:   if (sdram_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_oh     = 4'b0001 << sel;
  assign sdram_req  = (state == REQ);
  assign sdram_rfsh = (state == RFSH);
  assign sdram_ba   = sel;
  assign ba_ack     = (state == REQ && sdram_gnt) ? sel_oh : 4'd0;
  assign ba_dst     = (state == WAIT && sdram_dst && !sdram_wr) ? sel_oh : 4'd0;
  assign ba_rdy     = (state == WAIT && sdram_rdy) ? sel_oh : 4'd0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_jtcps1_bank_sched.sv
// Directed bench for jtcps1_bank_sched: table-driven round-robin vectors plus
// hand sequences for write latching, bursts, timeout, reset abort and refresh.
module tb_jtcps1_bank_sched;

  localparam int AW = 23;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RFSH  = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          LVBL = 1'b1;
  logic [AW-1:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
  logic [3:0]    ba_rd = 4'd0;
  logic          ba_wr = 1'b0;
  logic [15:0]   ba0_din = 16'd0;
  logic [1:0]    ba0_din_m = 2'd0;
  logic [3:0]    ba_ack, ba_dst, ba_rdy;
  logic          sdram_req, sdram_rfsh, sdram_wr, err;
  logic [1:0]    sdram_ba, sdram_mask;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic          sdram_gnt = 1'b0, sdram_dst = 1'b0, sdram_rdy = 1'b0;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic       sb_on = 1'b0;

  jtcps1_bank_sched dut (
    .clk(clk), .rst(rst), .LVBL(LVBL),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .sdram_req(sdram_req), .sdram_rfsh(sdram_rfsh), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_wr(sdram_wr), .sdram_din(sdram_din),
    .sdram_mask(sdram_mask), .sdram_gnt(sdram_gnt), .sdram_dst(sdram_dst),
    .sdram_rdy(sdram_rdy), .err(err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Grant-order scoreboard, enabled during the arbitration sequences.
  always @(negedge clk) begin
    #2;
    if (sb_on && ba_ack != 4'd0) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ack", {28'd0, ba_ack}, 32'd0);
      else chk("sb_ack_order", {28'd0, ba_ack}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ba_rd = 4'd0; ba_wr = 1'b0;
    sdram_gnt = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_pulses", {16'd0, ba_ack, ba_dst, ba_rdy, sdram_req, sdram_rfsh, sdram_wr, err}, 32'd0);
    chk("rst_cmd", {sdram_ba, sdram_mask, sdram_din}, 32'd0);
    chk("rst_addr", {9'd0, sdram_addr}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] rd;
    logic       gnt;
    logic       dst;
    logic       rdy;
    logic [3:0] e_ack;
    logic [3:0] e_dst;
    logic [3:0] e_rdy;
    logic       e_req;
    logic [1:0] e_ba;
    logic [2:0] e_st;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int first1, first2, n;
    logic bad;

    tbl[0]  = '{4'b0110, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_IDLE};
    tbl[1]  = '{4'b0110, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, S_REQ};
    tbl[2]  = '{4'b0110, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 1, S_REQ};
    tbl[3]  = '{4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_WAIT};
    tbl[4]  = '{4'b0100, 0, 1, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0, S_WAIT};
    tbl[5]  = '{4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_WAIT};
    tbl[6]  = '{4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 0, S_WAIT};
    tbl[7]  = '{4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_IDLE};
    tbl[8]  = '{4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 2, S_REQ};
    tbl[9]  = '{4'b0100, 1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 2, S_REQ};
    tbl[10] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_WAIT};
    tbl[11] = '{4'b0000, 0, 1, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0, S_WAIT};
    tbl[12] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_WAIT};
    tbl[13] = '{4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 0, S_WAIT};
    tbl[14] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_IDLE};
    tbl[15] = '{4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, S_IDLE};

    ba0_addr = 23'h300010; ba1_addr = 23'h011111;
    ba2_addr = 23'h022222; ba3_addr = 23'h012345;
    ba0_din = 16'hBEEF; ba0_din_m = 2'b01;

    do_reset();

    // T1: banks 1 and 2 served in round-robin order
    sb_on = 1'b1;
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b1000);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      ba_rd = tbl[i].rd; sdram_gnt = tbl[i].gnt;
      sdram_dst = tbl[i].dst; sdram_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("t1_ack[%0d]", i), {28'd0, ba_ack}, {28'd0, tbl[i].e_ack});
      chk($sformatf("t1_dst[%0d]", i), {28'd0, ba_dst}, {28'd0, tbl[i].e_dst});
      chk($sformatf("t1_rdy[%0d]", i), {28'd0, ba_rdy}, {28'd0, tbl[i].e_rdy});
      chk($sformatf("t1_req[%0d]", i), {31'd0, sdram_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("t1_state[%0d]", i), {29'd0, dbg_state}, {29'd0, tbl[i].e_st});
      if (tbl[i].e_req) chk($sformatf("t1_ba[%0d]", i), {30'd0, sdram_ba}, {30'd0, tbl[i].e_ba});
    end

    // T2: bank-0 write beats pending bank 3 although round-robin favours bank 3
    @(negedge clk);
    ba_rd = 4'b1000; ba_wr = 1'b1; #1;
    chk("t2_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    @(negedge clk); #1;
    chk("t2_req", {31'd0, sdram_req}, 32'd1);
    chk("t2_ba", {30'd0, sdram_ba}, 32'd0);
    chk("t2_wr", {31'd0, sdram_wr}, 32'd1);
    chk("t2_addr", {9'd0, sdram_addr}, 32'h300010);
    chk("t2_din", {16'd0, sdram_din}, 32'hBEEF);
    chk("t2_mask", {30'd0, sdram_mask}, 32'd1);
    @(negedge clk); sdram_gnt = 1'b1; #1;
    chk("t2_ack", {28'd0, ba_ack}, 32'b0001);
    @(negedge clk); sdram_gnt = 1'b0; ba_wr = 1'b0; sdram_dst = 1'b1; #1;
    chk("t2_wr_no_dst", {28'd0, ba_dst}, 32'd0);
    @(negedge clk); sdram_dst = 1'b0; sdram_rdy = 1'b1; #1;
    chk("t2_rdy", {28'd0, ba_rdy}, 32'b0001);
    @(negedge clk); sdram_rdy = 1'b0; #1;
    chk("t2_back_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    @(negedge clk); #1;
    chk("t2_b3_ba", {30'd0, sdram_ba}, 32'd3);
    chk("t2_b3_rd", {31'd0, sdram_wr}, 32'd0);
    chk("t2_b3_addr", {9'd0, sdram_addr}, 32'h012345);
    @(negedge clk); sdram_gnt = 1'b1; #1;
    chk("t2_b3_ack", {28'd0, ba_ack}, 32'b1000);

    // T4: single-word burst, dst and rdy together
    @(negedge clk); sdram_gnt = 1'b0; ba_rd = 4'd0; sdram_dst = 1'b1; sdram_rdy = 1'b1; #1;
    chk("t4_dst", {28'd0, ba_dst}, 32'b1000);
    chk("t4_rdy", {28'd0, ba_rdy}, 32'b1000);
    @(negedge clk); sdram_dst = 1'b0; sdram_rdy = 1'b0; #1;
    chk("t4_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    sb_on = 1'b0;
    chk("sb_drained", exp_q.size(), 32'd0);

    // T5: no rdy after grant -> abort after 255 WAIT cycles
    do_reset();
    ba_rd = 4'b0100; #1;
    @(negedge clk); sdram_gnt = 1'b1; #1;
    chk("t5_ack", {28'd0, ba_ack}, 32'b0100);
    bad = 1'b0;
    for (int w = 1; w <= 255; w++) begin
      @(negedge clk); sdram_gnt = 1'b0; ba_rd = 4'd0; #1;
      if (dbg_state != S_WAIT || ba_rdy != 4'd0 || err != 1'b0) bad = 1'b1;
    end
    chk("t5_wait_255", {31'd0, bad}, 32'd0);
    @(negedge clk); ba_rd = 4'b0001; #1;
    chk("t5_abort_idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_no_rdy", {28'd0, ba_rdy}, 32'd0);
    @(negedge clk); sdram_gnt = 1'b1; #1;
    chk("t5_next_ba", {30'd0, sdram_ba}, 32'd0);
    chk("t5_next_ack", {28'd0, ba_ack}, 32'b0001);
    @(negedge clk); sdram_gnt = 1'b0; ba_rd = 4'd0; sdram_rdy = 1'b1; #1;
    chk("t5_next_rdy", {28'd0, ba_rdy}, 32'b0001);
    chk("t5_err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk); sdram_rdy = 1'b0;

    // T6: reset mid-WAIT aborts; first grant afterwards is bank 0
    ba_rd = 4'b1110; #1;
    @(negedge clk); sdram_gnt = 1'b1; #1;
    chk("t6_ack", {28'd0, ba_ack}, 32'b0010);
    @(negedge clk); sdram_gnt = 1'b0; #1;
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_in_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
    @(negedge clk); sdram_dst = 1'b1; sdram_rdy = 1'b1; sdram_gnt = 1'b1; #1;
    chk("t6_outs_zero", {16'd0, ba_ack, ba_dst, ba_rdy, sdram_req, sdram_rfsh, sdram_wr, err}, 32'd0);
    chk("t6_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    @(negedge clk); rst = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; sdram_gnt = 1'b0;
    ba_rd = 4'b1111; #1;
    @(negedge clk); #1;
    chk("t6_first_req", {31'd0, sdram_req}, 32'd1);
    chk("t6_first_ba", {30'd0, sdram_ba}, 32'd0);

    // T3: refresh held off by active video, then taken at once in vblank
    do_reset();
    LVBL = 1'b1; ba_rd = 4'b1000;
    first1 = 0; first2 = 0; n = 0; bad = 1'b0;
    while (n < 1600) begin
      @(negedge clk);
      n++;
      if (n == 900) LVBL = 1'b0;
      sdram_gnt = sdram_req | sdram_rfsh;
      sdram_rdy = (dbg_state == S_WAIT) || (dbg_state == S_RWAIT);
      #1;
      if (sdram_req && sdram_rfsh) bad = 1'b1;
      if ((dbg_state == S_RFSH || dbg_state == S_RWAIT) && (ba_ack | ba_rdy | ba_dst) != 4'd0) bad = 1'b1;
      if (sdram_rfsh && first1 == 0) first1 = n;
      if (sdram_rfsh && n > 900 && first2 == 0) first2 = n;
    end
    sdram_gnt = 1'b0; sdram_rdy = 1'b0; ba_rd = 4'd0;
    chk("t3_invariants", {31'd0, bad}, 32'd0);
    chk("t3_active_video_held", {31'd0, (first1 >= 815 && first1 <= 818)}, 32'd1);
    chk("t3_vblank_prompt", {31'd0, (first2 >= 1501 && first2 <= 1503)}, 32'd1);
    if (!(first1 >= 815 && first1 <= 818) || !(first2 >= 1501 && first2 <= 1503))
      $display("  refresh seen at cycles %0d and %0d", first1, first2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
